cov_systolic_feeder: RTL and testbench



---
 rtl/cov_systolic_feeder_pkg.sv | 33 +++
 rtl/cov_systolic_feeder_buffer.sv | 69 ++++++
 rtl/cov_systolic_feeder.sv | 154 +++++++++++++++
 tb/tb_cov_systolic_feeder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cov_systolic_feeder_pkg.sv
// Shared types and helpers for the covariance systolic-array feeder.
// Optional centering build: define COV_MEAN_CENTER_EN.
package pca_cov_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_e;

  // Sample counter must hold the value N itself, hence the extra bit.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int log2_n(input int n);
    return $clog2(n);
  endfunction

  function automatic int sat_signed(input int v, input int dw);
    int hi;
    int lo;
    hi = (1 << (dw - 1)) - 1;
    lo = -(1 << (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cov_systolic_feeder_buffer.sv
// N-entry two-feature sample store with write pointer and k / k-1 read ports.
// With COV_MEAN_CENTER_EN it also keeps per-feature running sums and exposes the means.
module cov_sample_buffer
  import pca_cov_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_SAMPLES  = 4,
  localparam int CNT_W     = cnt_width(N_SAMPLES),
  localparam int LOG2_N    = log2_n(N_SAMPLES)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic                         clr_i,
  input  logic [2*DATA_WIDTH-1:0]      wr_data_i,
  input  logic [LOG2_N-1:0]            rd0_idx_i,
  input  logic [LOG2_N-1:0]            rd1_idx_i,
  output logic [CNT_W-1:0]             wr_cnt_o,
  output logic signed [DATA_WIDTH-1:0] rd0_f0_o,
  output logic signed [DATA_WIDTH-1:0] rd1_f1_o
`ifdef COV_MEAN_CENTER_EN
  ,
  output logic signed [DATA_WIDTH-1:0] mean0_o,
  output logic signed [DATA_WIDTH-1:0] mean1_o
`endif
);

  logic [2*DATA_WIDTH-1:0] mem_q [N_SAMPLES];
  logic [CNT_W-1:0]        wr_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        wr_ptr_q <= '0;
    else if (clr_i)   wr_ptr_q <= '0;
    else if (wr_en_i) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[LOG2_N-1:0]] <= wr_data_i;
  end

  assign wr_cnt_o = wr_ptr_q;
  assign rd0_f0_o = mem_q[rd0_idx_i][DATA_WIDTH-1:0];
  assign rd1_f1_o = mem_q[rd1_idx_i][2*DATA_WIDTH-1:DATA_WIDTH];

`ifdef COV_MEAN_CENTER_EN
  localparam int SUM_W = DATA_WIDTH + LOG2_N;

  logic signed [SUM_W-1:0]      sum0_q, sum1_q;
  logic signed [DATA_WIDTH-1:0] in_f0, in_f1;

  assign in_f0 = wr_data_i[DATA_WIDTH-1:0];
  assign in_f1 = wr_data_i[2*DATA_WIDTH-1:DATA_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clr_i) begin
      sum0_q <= '0;
      sum1_q <= '0;
    end else if (wr_en_i) begin
      sum0_q <= sum0_q + SUM_W'(in_f0);
      sum1_q <= sum1_q + SUM_W'(in_f1);
    end
  end

  // Dropping the low LOG2_N bits of a two's-complement sum is sum >>> LOG2_N (floor).
  assign mean0_o = sum0_q[SUM_W-1:LOG2_N];
  assign mean1_o = sum1_q[SUM_W-1:LOG2_N];
`endif

endmodule

// File: rtl/cov_systolic_feeder.sv
// Feeder for the 2x2 covariance systolic array: buffer N samples, clear, stream skewed operands, drain.
// Optional mean centering of streamed lanes: define COV_MEAN_CENTER_EN.
module cov_systolic_feeder
  import pca_cov_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int N_SAMPLES    = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  output logic                    array_clr,
  output logic [2*DATA_WIDTH-1:0] A_in,
  output logic [2*DATA_WIDTH-1:0] B_in,
  output logic                    feed_active,
  output logic                    done
);

  localparam int CNT_W  = cnt_width(N_SAMPLES);
  localparam int LOG2_N = log2_n(N_SAMPLES);
  localparam int DRN_W  = $clog2(DRAIN_CYCLES + 1);

  state_e                       state_q;
  logic [CNT_W-1:0]             k_q, rd_k, wr_cnt;
  logic [DRN_W-1:0]             drn_q;
  logic                         s_ready_q, clr_q, feed_q, done_q;
  logic [2*DATA_WIDTH-1:0]      op_q, op_d;
  logic [DATA_WIDTH-1:0]        lane0, lane1;
  logic signed [DATA_WIDTH-1:0] rd0_f0, rd1_f1;
  logic                         xfer, last_wr;

  assign xfer    = s_valid && s_ready_q;
  assign last_wr = xfer && (wr_cnt == CNT_W'(N_SAMPLES - 1));
  // Operands are registered, so read the slot for the k about to be presented.
  assign rd_k    = (state_q == STREAM) ? k_q + CNT_W'(1) : '0;

`ifdef COV_MEAN_CENTER_EN
  logic signed [DATA_WIDTH-1:0] mean0, mean1;

  function automatic logic [DATA_WIDTH-1:0] center(input logic signed [DATA_WIDTH-1:0] x,
                                                   input logic signed [DATA_WIDTH-1:0] m);
    logic signed [DATA_WIDTH+1:0] diff;
    int                           sat;
    diff = (DATA_WIDTH + 2)'(x) - (DATA_WIDTH + 2)'(m);
    sat  = sat_signed(int'(diff), DATA_WIDTH);
    return sat[DATA_WIDTH-1:0];
  endfunction
`endif

  cov_sample_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .N_SAMPLES (N_SAMPLES)
  ) u_buf (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (xfer),
    .clr_i    (state_q == DONE),
    .wr_data_i(s_data),
    .rd0_idx_i(rd_k[LOG2_N-1:0]),
    .rd1_idx_i(rd_k[LOG2_N-1:0] - LOG2_N'(1)),
    .wr_cnt_o (wr_cnt),
    .rd0_f0_o (rd0_f0),
    .rd1_f1_o (rd1_f1)
`ifdef COV_MEAN_CENTER_EN
    ,
    .mean0_o  (mean0),
    .mean1_o  (mean1)
`endif
  );

  // Skew: lane0 leads with f0 of sample k, lane1 trails one slot with f1 of sample k-1.
  always_comb begin
    lane0 = '0;
    lane1 = '0;
`ifdef COV_MEAN_CENTER_EN
    if (rd_k < CNT_W'(N_SAMPLES)) lane0 = center(rd0_f0, mean0);
    if (rd_k != '0)               lane1 = center(rd1_f1, mean1);
`else
    if (rd_k < CNT_W'(N_SAMPLES)) lane0 = rd0_f0;
    if (rd_k != '0)               lane1 = rd1_f1;
`endif
    op_d = {lane1, lane0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      drn_q     <= '0;
      s_ready_q <= 1'b1;
      clr_q     <= 1'b0;
      feed_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= '0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      op_q   <= '0;
      case (state_q)
        IDLE, FILL: begin
          if (xfer) begin
            if (last_wr) begin
              state_q   <= CLEAR;
              s_ready_q <= 1'b0;
              clr_q     <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end
        end
        CLEAR: begin
          state_q <= STREAM;
          k_q     <= '0;
          feed_q  <= 1'b1;
          op_q    <= op_d;
        end
        STREAM: begin
          if (k_q == CNT_W'(N_SAMPLES)) begin
            state_q <= DRAIN;
            drn_q   <= '0;
          end else begin
            k_q  <= k_q + CNT_W'(1);
            op_q <= op_d;
          end
        end
        DRAIN: begin
          if (drn_q == DRN_W'(DRAIN_CYCLES - 1)) begin
            state_q <= DONE;
            feed_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drn_q <= drn_q + DRN_W'(1);
          end
        end
        DONE: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign array_clr   = clr_q;
  assign A_in        = op_q;
  assign B_in        = op_q;
  assign feed_active = feed_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cov_systolic_feeder.sv
// Directed bench for cov_systolic_feeder (N=4, DW=8, DRAIN=3); centering vectors under COV_MEAN_CENTER_EN.
module tb_cov_systolic_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        array_clr;
  logic [15:0] A_in, B_in;
  logic        feed_active, done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0][7:0] f0;
    logic [3:0][7:0] f1;
    logic [4:0][7:0] l0;
    logic [4:0][7:0] l1;
  } vec_t;

  vec_t tbl[6];

  cov_systolic_feeder #(
    .DATA_WIDTH  (8),
    .N_SAMPLES   (4),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .array_clr  (array_clr),
    .A_in       (A_in),
    .B_in       (B_in),
    .feed_active(feed_active),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive four samples back-to-back; returns at the negedge of the CLEAR cycle.
  task automatic send_samples(input vec_t v, input bit drop);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = {v.f1[i], v.f0[i]};
      @(negedge clk);
    end
    if (drop) s_valid = 1'b0;
  endtask

  // Starts at the CLEAR-cycle negedge; ends at the negedge after done.
  task automatic check_stream(input vec_t v, input string tag);
    check($sformatf("%s clr", tag), 32'(array_clr), 32'd1);
    check($sformatf("%s clr A", tag), 32'(A_in), 32'd0);
    check($sformatf("%s clr rdy", tag), 32'(s_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("%s A k=%0d", tag, k), 32'(A_in), 32'({v.l1[k], v.l0[k]}));
      check($sformatf("%s B k=%0d", tag, k), 32'(B_in), 32'({v.l1[k], v.l0[k]}));
      check($sformatf("%s feed k=%0d", tag, k), {30'd0, feed_active, array_clr}, 32'd2);
      check($sformatf("%s rdy k=%0d", tag, k), 32'(s_ready), 32'd0);
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      check($sformatf("%s drain A d=%0d", tag, d), 32'(A_in), 32'd0);
      check($sformatf("%s drain feed/done d=%0d", tag, d), {30'd0, feed_active, done}, 32'd2);
    end
    @(negedge clk);
    check($sformatf("%s done", tag), {29'd0, done, feed_active, s_ready}, 32'd4);
    @(negedge clk);
    check($sformatf("%s post done", tag), {30'd0, done, s_ready}, 32'd1);
  endtask

  initial begin
`ifndef COV_MEAN_CENTER_EN
    logic [5:0]       gpat;
    logic [5:0][15:0] gdat;
`endif
`ifdef COV_MEAN_CENTER_EN
    tbl[0].f0 = {8'd8, 8'd6, 8'd4, 8'd2};
    tbl[0].f1 = {8'd10, 8'd10, 8'd10, 8'd10};
    tbl[0].l0 = {8'h00, 8'h03, 8'h01, 8'hFF, 8'hFD};
    tbl[0].l1 = '0;
    tbl[1].f0 = {8'h7F, 8'h80, 8'h80, 8'h80};
    tbl[1].f1 = '0;
    tbl[1].l0 = {8'h00, 8'h7F, 8'hC1, 8'hC1, 8'hC1};
    tbl[1].l1 = '0;
`else
    tbl[0].f0 = {8'd7, 8'd5, 8'd3, 8'd1};
    tbl[0].f1 = {8'd8, 8'd6, 8'd4, 8'd2};
    tbl[0].l0 = {8'd0, 8'd7, 8'd5, 8'd3, 8'd1};
    tbl[0].l1 = {8'd8, 8'd6, 8'd4, 8'd2, 8'd0};
    tbl[1].f0 = {8'h00, 8'h7F, 8'h10, 8'hFF};
    tbl[1].f1 = {8'hAA, 8'h01, 8'h20, 8'h80};
    tbl[1].l0 = {8'h00, 8'h00, 8'h7F, 8'h10, 8'hFF};
    tbl[1].l1 = {8'hAA, 8'h01, 8'h20, 8'h80, 8'h00};
`endif
    tbl[2].f0 = '0;
    tbl[2].f1 = '0;
    tbl[2].l0 = {8'h00, 8'h66, 8'h44, 8'h33, 8'h11};
    tbl[2].l1 = {8'h76, 8'h54, 8'h43, 8'h21, 8'h00};
    tbl[3].f0 = {8'd9, 8'd9, 8'd9, 8'd9};
    tbl[3].f1 = {8'd9, 8'd9, 8'd9, 8'd9};
    tbl[3].l0 = {8'd0, 8'd9, 8'd9, 8'd9, 8'd9};
    tbl[3].l1 = {8'd9, 8'd9, 8'd9, 8'd9, 8'd0};
    tbl[4].f0 = {8'h04, 8'h03, 8'h02, 8'h01};
    tbl[4].f1 = {8'h40, 8'h30, 8'h20, 8'h10};
    tbl[4].l0 = {8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    tbl[4].l1 = {8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
    tbl[5].f0 = {8'h08, 8'h07, 8'h06, 8'h05};
    tbl[5].f1 = {8'h80, 8'h70, 8'h60, 8'h50};
    tbl[5].l0 = {8'h00, 8'h08, 8'h07, 8'h06, 8'h05};
    tbl[5].l1 = {8'h80, 8'h70, 8'h60, 8'h50, 8'h00};

    // Reset state
    #12;
    check("rst A_in", 32'(A_in), 32'd0);
    check("rst B_in", 32'(B_in), 32'd0);
    check("rst ctl", {29'd0, array_clr, feed_active, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst s_ready", 32'(s_ready), 32'd1);

    // Table-driven blocks
    for (int t = 0; t < 2; t++) begin
      send_samples(tbl[t], 1'b1);
      check_stream(tbl[t], $sformatf("tbl%0d", t));
    end

`ifndef COV_MEAN_CENTER_EN
    // Gapped input, then s_valid held high through the block
    gpat = 6'b101101;
    gdat = {16'h7666, 16'hEEEE, 16'h5444, 16'h4333, 16'hEEEE, 16'h2111};
    for (int j = 0; j < 6; j++) begin
      s_valid = gpat[j];
      s_data  = gdat[j];
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = 16'h5555;
    check_stream(tbl[2], "gap");
    s_valid = 1'b0;

    // Asynchronous reset at STREAM k=2
    send_samples(tbl[0], 1'b1);
    repeat (3) @(negedge clk);
    check("abort pre A k=2", 32'(A_in), 32'h0405);
    #2 rst = 1'b1;
    #1;
    check("abort A_in", 32'(A_in), 32'd0);
    check("abort B_in", 32'(B_in), 32'd0);
    check("abort feed", 32'(feed_active), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort s_ready", 32'(s_ready), 32'd1);
    send_samples(tbl[3], 1'b1);
    check_stream(tbl[3], "after abort");

    // Back-to-back blocks with s_valid held high
    send_samples(tbl[4], 1'b0);
    s_data = {tbl[5].f1[0], tbl[5].f0[0]};
    check_stream(tbl[4], "b2b A");
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      s_data = {tbl[5].f1[i], tbl[5].f0[i]};
    end
    @(negedge clk);
    s_valid = 1'b0;
    check_stream(tbl[5], "b2b B");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
